// File: rtl/pitch_sequencer.sv
// Pitch sequencer: button start, timed wind-up, one-clk release strobe, speed/mode dependent flight, cool-down.
// Latency: one clk from start edge to ARM; timed states advance on tick. No backpressure; abort only before release.
module pitch_sequencer #(
    parameter int unsigned WINDUP_TICKS   = 3,
    parameter int unsigned COOLDOWN_TICKS = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       tick,
    input  logic       pitchReq,
    input  logic       abortReq,
    input  logic [3:0] speedCode,
    input  logic [1:0] mode,
    output logic [2:0] state,
    output logic       busy,
    output logic [3:0] latchedSpeed,
    output logic [1:0] latchedMode,
    output logic [3:0] countdown,
    output logic       releasePulse,
    output logic [7:0] pitchCount
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WINDUP   = 3'd2,
        S_RELEASE  = 3'd3,
        S_FLIGHT   = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    localparam logic [3:0] WINDUP_LOAD   = WINDUP_TICKS[3:0];
    localparam logic [3:0] COOLDOWN_LOAD = COOLDOWN_TICKS[3:0];

    state_t     state_q;
    logic       req_q;
    logic       start;
    logic [3:0] mode_add;
    logic [3:0] flight_load;

    assign start = pitchReq & ~req_q;

    // latchedSpeed is clamped to 0..8, so 12 - speed + 3 never exceeds 15
    assign mode_add    = (latchedMode == 2'd2) ? 4'd3 :
                         (latchedMode == 2'd1) ? 4'd1 : 4'd0;
    assign flight_load = (4'd12 - latchedSpeed) + mode_add;

    assign state = state_q;
    assign busy  = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b1;
            countdown    <= 4'd0;
            releasePulse <= 1'b0;
            pitchCount   <= 8'd0;
            latchedSpeed <= 4'd3;
            latchedMode  <= 2'd0;
        end else begin
            req_q        <= pitchReq;
            releasePulse <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_ARM;
                        latchedSpeed <= (speedCode > 4'd8) ? 4'd8 : speedCode;
                        latchedMode  <= (mode == 2'd3) ? 2'd0 : mode;
                    end
                end
                S_ARM: begin
                    if (abortReq) begin
                        state_q   <= S_IDLE;
                        countdown <= 4'd0;
                    end else if (tick) begin
                        state_q   <= S_WINDUP;
                        countdown <= WINDUP_LOAD;
                    end
                end
                S_WINDUP: begin
                    if (abortReq) begin
                        state_q   <= S_IDLE;
                        countdown <= 4'd0;
                    end else if (tick) begin
                        if (countdown == 4'd1) begin
                            state_q      <= S_RELEASE;
                            countdown    <= 4'd0;
                            releasePulse <= 1'b1;
                            if (pitchCount != 8'hFF)
                                pitchCount <= pitchCount + 8'd1;
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    state_q   <= S_FLIGHT;
                    countdown <= flight_load;
                end
                S_FLIGHT: begin
                    if (tick) begin
                        if (countdown == 4'd1) begin
                            state_q   <= S_COOLDOWN;
                            countdown <= COOLDOWN_LOAD;
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (tick) begin
                        if (countdown == 4'd1) begin
                            state_q   <= S_IDLE;
                            countdown <= 4'd0;
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    countdown <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pitch_sequencer.sv
// Directed bench for pitch_sequencer; each release is scored against a queue of expected pitches.
module tb_pitch_sequencer;
    logic       clk = 1'b0;
    logic       rstN;
    logic       tick;
    logic       pitchReq;
    logic       abortReq;
    logic [3:0] speedCode;
    logic [1:0] mode;
    logic [2:0] state;
    logic       busy;
    logic [3:0] latchedSpeed;
    logic [1:0] latchedMode;
    logic [3:0] countdown;
    logic       releasePulse;
    logic [7:0] pitchCount;

    pitch_sequencer #(.WINDUP_TICKS(3), .COOLDOWN_TICKS(4)) dut (
        .clk(clk), .rstN(rstN), .tick(tick), .pitchReq(pitchReq), .abortReq(abortReq),
        .speedCode(speedCode), .mode(mode), .state(state), .busy(busy),
        .latchedSpeed(latchedSpeed), .latchedMode(latchedMode), .countdown(countdown),
        .releasePulse(releasePulse), .pitchCount(pitchCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lspd;
        int lmd;
        int load;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errs    = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // tick every 4 clk
    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(3);
    endtask

    task automatic push_exp(input int lspd, input int lmd, input int load);
        exp_t e;
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        e.lspd = lspd; e.lmd = lmd; e.load = load; e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    // Monitor: every release must match the oldest expected pitch
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (releasePulse) begin
                if (q.size() == 0) begin
                    chk("unexpected_release", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rel_lspd", int'(latchedSpeed), e.lspd);
                    chk("rel_lmd", int'(latchedMode), e.lmd);
                    chk("rel_count", int'(pitchCount), e.cnt);
                    chk("rel_state", int'(state), 3);
                    @(negedge clk);
                    chk("rel_width", int'(releasePulse), 0);
                    chk("flight_state", int'(state), 4);
                    chk("flight_load", int'(countdown), e.load);
                end
            end
        end
    end

    task automatic run_pitch(input int spd, input int md, input int lspd, input int lmd,
                             input int load, input bit disturb);
        speedCode = 4'(spd);
        mode      = 2'(md);
        pitchReq  = 1'b1;
        step(1);
        chk("arm_state", int'(state), 1);
        chk("arm_busy", int'(busy), 1);
        chk("arm_lspd", int'(latchedSpeed), lspd);
        chk("arm_lmd", int'(latchedMode), lmd);
        push_exp(lspd, lmd, load);
        do_tick();
        chk("windup_3", int'(countdown), 3);
        do_tick();
        chk("windup_2", int'(countdown), 2);
        do_tick();
        chk("windup_1", int'(countdown), 1);
        do_tick();
        if (disturb) begin
            abortReq  = 1'b1;
            speedCode = 4'(spd) ^ 4'd5;
            mode      = 2'(md) + 2'd1;
        end
        repeat (load - 1) do_tick();
        chk("flight_last_state", int'(state), 4);
        chk("flight_last_cd", int'(countdown), 1);
        chk("lock_lspd", int'(latchedSpeed), lspd);
        chk("lock_lmd", int'(latchedMode), lmd);
        abortReq = 1'b0;
        do_tick();
        chk("cool_state", int'(state), 5);
        chk("cool_cd", int'(countdown), 4);
        if (disturb) begin
            pitchReq = 1'b0;
            step(1);
            pitchReq = 1'b1;
            step(1);
            chk("cool_retrig", int'(state), 5);
        end
        repeat (4) do_tick();
        chk("done_state", int'(state), 0);
        chk("done_busy", int'(busy), 0);
        chk("done_cd", int'(countdown), 0);
        chk("done_count", int'(pitchCount), exp_cnt);
        if (disturb) begin
            repeat (3) do_tick();
            chk("held_no_retrig", int'(state), 0);
        end
        pitchReq = 1'b0;
        step(1);
    endtask

    initial begin
        rstN = 1'b0; tick = 1'b0; pitchReq = 1'b1; abortReq = 1'b0;
        speedCode = 4'd0; mode = 2'd0;
        step(2);
        chk("rst_state", int'(state), 0);
        chk("rst_cd", int'(countdown), 0);
        chk("rst_count", int'(pitchCount), 0);
        chk("rst_lspd", int'(latchedSpeed), 3);
        chk("rst_lmd", int'(latchedMode), 0);
        rstN = 1'b1;
        step(3);
        chk("rst_held_req", int'(state), 0);
        pitchReq = 1'b0;
        step(1);

        run_pitch(3, 0, 3, 0, 9, 1'b0);
        run_pitch(8, 0, 8, 0, 4, 1'b0);
        run_pitch(0, 2, 0, 2, 15, 1'b0);
        run_pitch(12, 1, 8, 1, 5, 1'b0);
        run_pitch(5, 3, 5, 0, 7, 1'b0);
        run_pitch(2, 1, 2, 1, 11, 1'b1);

        // Abort in WINDUP on the same clk as a tick
        speedCode = 4'd4; mode = 2'd0; pitchReq = 1'b1;
        step(1);
        do_tick();
        do_tick();
        chk("abort_pre_cd", int'(countdown), 2);
        abortReq = 1'b1; tick = 1'b1;
        step(1);
        abortReq = 1'b0; tick = 1'b0;
        chk("abort_state", int'(state), 0);
        chk("abort_cd", int'(countdown), 0);
        step(3);
        do_tick();
        chk("abort_count", int'(pitchCount), exp_cnt);
        pitchReq = 1'b0;
        step(1);

        // Reset mid-flight with pitchReq held high
        speedCode = 4'd3; mode = 2'd0; pitchReq = 1'b1;
        step(1);
        push_exp(3, 0, 9);
        repeat (5) do_tick();
        chk("pre_rst_state", int'(state), 4);
        chk("pre_rst_cd", int'(countdown), 8);
        rstN = 1'b0;
        step(1);
        exp_cnt = 0;
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_cd", int'(countdown), 0);
        chk("mid_rst_rel", int'(releasePulse), 0);
        chk("mid_rst_count", int'(pitchCount), 0);
        chk("mid_rst_lspd", int'(latchedSpeed), 3);
        chk("mid_rst_lmd", int'(latchedMode), 0);
        rstN = 1'b1;
        do_tick();
        do_tick();
        chk("post_rst_no_start", int'(state), 0);
        pitchReq = 1'b0;
        step(1);
        run_pitch(6, 2, 6, 2, 9, 1'b0);

        // Saturation with tick every clk: a pitch completes in 14 clk
        speedCode = 4'd8; mode = 2'd0; tick = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pitchReq = 1'b1;
            push_exp(8, 0, 4);
            step(1);
            pitchReq = 1'b0;
            step(14);
        end
        tick = 1'b0;
        step(2);
        chk("sat_count", int'(pitchCount), 255);
        chk("sat_state", int'(state), 0);
        chk("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
